digit_packer: RTL

- Inverse of the score/display digit extractor: takes a serial stream of decimal digits, most significant first, and rebuilds the binary value.
- Used by the score-entry/high-score path, where digits arrive one per handshake from menu input or ROM.
- Delivers the packed value with a valid/ready handshake.
- Flags bad digits, too many digits and arithmetic overflow.

---
 rtl/digit_pkg.sv | 14 +
 rtl/mul10_add.sv | 23 ++
 rtl/digit_packer.sv | 102 ++++++++++
 3 files changed

// File: rtl/digit_pkg.sv
// Shared definitions for the decimal digit packer and related score-path logic.
package digit_pkg;

  localparam int DIGIT_W  = 4;
  localparam int DEC_BASE = 10;

  typedef enum logic {ACCUM, DONE} pack_state_t;

  // True for the BCD codes 0..9; codes 10..15 are not decimal digits.
  function automatic logic is_dec_digit(logic [DIGIT_W-1:0] d);
    return d < DIGIT_W'(DEC_BASE);
  endfunction

endpackage

// File: rtl/mul10_add.sv
// acc*10 + digit using shifts and adds only; ovf flags any carry past VALUE_W bits.
// Shared with the score incrementer.
module mul10_add
  import digit_pkg::*;
#(
  parameter int VALUE_W = 32
) (
  input  logic [VALUE_W-1:0] acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [VALUE_W-1:0] sum,
  output logic               ovf
);

  // Four spare bits hold the largest possible result: (2^W-1)*10 + 15 < 2^(W+4).
  logic [VALUE_W+3:0] acc_w;
  logic [VALUE_W+3:0] wide;

  assign acc_w = {4'b0000, acc};
  assign wide  = (acc_w << 3) + (acc_w << 1) + {{VALUE_W{1'b0}}, digit};
  assign sum   = wide[VALUE_W-1:0];
  assign ovf   = |wide[VALUE_W+3:VALUE_W];

endmodule

// File: rtl/digit_packer.sv
// Serial decimal digits (MSD first) -> binary value with valid/ready output.
// Optional build macro: DIGIT_PACKER_SAT_EN (saturate value to all-ones on err).
//
// state | meaning
// ACCUM | accepting digits, digit_ready=1
// DONE  | result presented, value_valid=1, outputs held until value_ready
module digit_packer
  import digit_pkg::*;
#(
  parameter int VALUE_W    = 32,
  parameter int MAX_DIGITS = 9
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic [3:0]         digit,
  input  logic               digit_last,
  output logic               value_valid,
  input  logic               value_ready,
  output logic [VALUE_W-1:0] value,
  output logic [3:0]         ndigits,
  output logic               err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  pack_state_t        state_q, state_d;
  logic [VALUE_W-1:0] acc_q, acc_d;
  logic [3:0]         count_q, count_d;
  logic               err_q, err_d;

  logic [VALUE_W-1:0] mac_sum;
  logic               mac_ovf;

  mul10_add #(.VALUE_W(VALUE_W)) u_mul10_add (
    .acc   (acc_q),
    .digit (digit),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  // Next-state: fold accepted digits into acc, close frame on last, clear on result handoff.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ACCUM: begin
        if (digit_valid) begin
          if (!is_dec_digit(digit)) begin
            err_d = 1'b1;
          end else if (count_q >= MAX_CNT) begin
            err_d = 1'b1;
          end else begin
            acc_d   = mac_sum;
            count_d = count_q + 4'd1;
            if (mac_ovf) err_d = 1'b1;
          end
          if (digit_last) state_d = DONE;
        end
      end
      DONE: begin
        if (value_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign digit_ready = (state_q == ACCUM);
  assign value_valid = (state_q == DONE);
  assign ndigits     = count_q;
  assign err         = err_q;

`ifdef DIGIT_PACKER_SAT_EN
  assign value = (value_valid && err_q) ? {VALUE_W{1'b1}} : acc_q;
`else
  assign value = acc_q;
`endif

endmodule
